// File: rtl/wf_valid_count.sv
// Per-wavefront instruction-buffer occupancy counters with saturating
// increment/decrement, flush on taken branch or page fault, and sticky error flags.
module wf_valid_count #(
    parameter int unsigned WF_PER_CU = 40,
    parameter int unsigned WFID_W    = 6,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned NUM_ISSUE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          decode_valid,
    input  logic                          decode_hold,
    input  logic [WFID_W-1:0]             decode_wfid,
    input  logic [NUM_ISSUE-1:0]          issue_valid,
    input  logic [NUM_ISSUE*WFID_W-1:0]   issue_wfid,
    input  logic                          branch_en,
    input  logic                          branch_taken,
    input  logic [WFID_W-1:0]             branch_wfid,
    input  logic                          fault_en,
    input  logic [6:0]                    fault_tag,
    output logic [WF_PER_CU-1:0]          valid_entry_out,
    output logic [WF_PER_CU-1:0]          full_out,
    output logic [WF_PER_CU*CNT_W-1:0]    count_out,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam logic [CNT_W+1:0] DEPTH_S = (CNT_W+2)'(DEPTH);

    logic [CNT_W-1:0] count_q [WF_PER_CU];
    logic [CNT_W-1:0] count_d [WF_PER_CU];
    logic             ovf_q;
    logic             unf_q;
    logic             ovf_set;
    logic             unf_set;
    logic             flush;
    logic [CNT_W+1:0] sum;
    logic             unused_fault_tag;

    assign unused_fault_tag = ^fault_tag;

    // sum is two's complement; its top bit marks a decrement below zero
    always_comb begin
        ovf_set = 1'b0;
        unf_set = 1'b0;
        flush   = 1'b0;
        sum     = '0;
        for (int unsigned w = 0; w < WF_PER_CU; w++) begin
            flush = (branch_en & branch_taken & (branch_wfid == WFID_W'(w)))
                  | (fault_en & (fault_tag[WFID_W-1:0] == WFID_W'(w)));
            sum = (CNT_W+2)'(count_q[w]);
            if (decode_valid && !decode_hold && (decode_wfid == WFID_W'(w)))
                sum = sum + (CNT_W+2)'(1);
            for (int unsigned p = 0; p < NUM_ISSUE; p++) begin
                if (issue_valid[p] && (issue_wfid[p*WFID_W +: WFID_W] == WFID_W'(w)))
                    sum = sum - (CNT_W+2)'(1);
            end
            if (flush) begin
                count_d[w] = '0;
            end else if (sum[CNT_W+1]) begin
                count_d[w] = '0;
                unf_set    = 1'b1;
            end else if (sum > DEPTH_S) begin
                count_d[w] = CNT_W'(DEPTH);
                ovf_set    = 1'b1;
            end else begin
                count_d[w] = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < WF_PER_CU; w++)
                count_q[w] <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < WF_PER_CU; w++)
                count_q[w] <= count_d[w];
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    always_comb begin
        valid_entry_out = '0;
        full_out        = '0;
        count_out       = '0;
        for (int unsigned w = 0; w < WF_PER_CU; w++) begin
            valid_entry_out[w]          = (count_q[w] != '0);
            full_out[w]                 = (count_q[w] == CNT_W'(DEPTH));
            count_out[w*CNT_W +: CNT_W] = count_q[w];
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_wf_valid_count.sv
// Bench for wf_valid_count: directed vector table, reset sequences, and
// randomized traffic against an integer reference model.
module tb_wf_valid_count;

    localparam int WF = 40;
    localparam int WW = 6;
    localparam int DEPTH = 2;
    localparam int CW = 4;
    localparam int NI = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                decode_valid, decode_hold;
    logic [WW-1:0]       decode_wfid;
    logic [NI-1:0]       issue_valid;
    logic [NI*WW-1:0]    issue_wfid;
    logic                branch_en, branch_taken;
    logic [WW-1:0]       branch_wfid;
    logic                fault_en;
    logic [6:0]          fault_tag;
    logic [WF-1:0]       valid_entry_out, full_out;
    logic [WF*CW-1:0]    count_out;
    logic                overflow_err, underflow_err;

    int checks = 0;
    int failures = 0;

    wf_valid_count #(
        .WF_PER_CU(WF), .WFID_W(WW), .DEPTH(DEPTH), .CNT_W(CW), .NUM_ISSUE(NI)
    ) dut (
        .clk(clk), .rst(rst),
        .decode_valid(decode_valid), .decode_hold(decode_hold), .decode_wfid(decode_wfid),
        .issue_valid(issue_valid), .issue_wfid(issue_wfid),
        .branch_en(branch_en), .branch_taken(branch_taken), .branch_wfid(branch_wfid),
        .fault_en(fault_en), .fault_tag(fault_tag),
        .valid_entry_out(valid_entry_out), .full_out(full_out), .count_out(count_out),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dv, dh, dwf, iv, iw0, iw1, be, bt, bwf, fe, ftag;
        int cwf, ecnt, eovf, eunf;
    } row_t;

    row_t tbl[$];

    function automatic row_t row(int dv, int dh, int dwf, int iv, int iw0, int iw1,
                                 int be, int bt, int bwf, int fe, int ftag,
                                 int cwf, int ecnt, int eovf, int eunf);
        row_t r;
        r = '{dv, dh, dwf, iv, iw0, iw1, be, bt, bwf, fe, ftag, cwf, ecnt, eovf, eunf};
        return r;
    endfunction

    task automatic chk(input string name, input logic [WF*CW-1:0] act, input logic [WF*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        decode_valid = 0; decode_hold = 0; decode_wfid = '0;
        issue_valid = '0; issue_wfid = '0;
        branch_en = 0; branch_taken = 0; branch_wfid = '0;
        fault_en = 0; fault_tag = '0;
    endtask

    task automatic drive_row(input row_t r);
        decode_valid = 1'(r.dv); decode_hold = 1'(r.dh); decode_wfid = WW'(r.dwf);
        issue_valid = NI'(r.iv);
        issue_wfid = {WW'(r.iw1), WW'(r.iw0)};
        branch_en = 1'(r.be); branch_taken = 1'(r.bt); branch_wfid = WW'(r.bwf);
        fault_en = 1'(r.fe); fault_tag = 7'(r.ftag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_count"}, count_out, '0);
        chk({name, "_valid_full"}, {valid_entry_out, full_out}, '0);
        chk({name, "_flags"}, {overflow_err, underflow_err}, '0);
    endtask

    int mc[WF];
    int movf, munf;

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        repeat (5) tick();
        chk_all_zero("reset_idle");

        // directed table; state carries from row to row
        tbl.push_back(row(1,0,3,  0,0,0,   0,0,0, 0,0,    3,1,0,0));
        tbl.push_back(row(1,0,3,  0,0,0,   0,0,0, 0,0,    3,2,0,0));
        tbl.push_back(row(0,0,0,  2,0,3,   0,0,0, 0,0,    3,1,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   0,0,0, 0,0,    9,1,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   0,0,0, 0,0,    9,2,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   1,1,9, 0,0,    9,0,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   0,0,0, 0,0,    9,1,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   0,0,0, 1,8'h49,9,0,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   0,0,0, 0,0,    9,1,0,0));
        tbl.push_back(row(1,0,9,  0,0,0,   1,0,9, 0,0,    9,2,0,0));
        tbl.push_back(row(1,0,45, 1,41,0,  0,0,0, 0,0,    9,2,0,0));
        tbl.push_back(row(1,1,3,  0,0,0,   0,0,0, 0,0,    3,1,0,0));
        tbl.push_back(row(1,0,7,  0,0,0,   0,0,0, 0,0,    7,1,0,0));
        tbl.push_back(row(1,0,7,  0,0,0,   0,0,0, 0,0,    7,2,0,0));
        tbl.push_back(row(1,0,7,  1,7,0,   0,0,0, 0,0,    7,2,0,0));
        tbl.push_back(row(1,0,7,  0,0,0,   0,0,0, 0,0,    7,2,1,0));
        tbl.push_back(row(0,0,0,  0,0,0,   0,0,0, 0,0,    7,2,1,0));
        tbl.push_back(row(1,0,5,  0,0,0,   0,0,0, 0,0,    5,1,1,0));
        tbl.push_back(row(0,0,0,  3,5,5,   0,0,0, 0,0,    5,0,1,1));
        tbl.push_back(row(0,0,0,  0,0,0,   0,0,0, 0,0,    3,1,1,1));
        tbl.push_back(row(0,0,0,  0,0,0,   0,0,0, 0,0,    9,2,1,1));
        tbl.push_back(row(0,0,0,  0,0,0,   0,0,0, 0,0,    7,2,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            row_t r;
            logic [CW-1:0] c;
            r = tbl[i];
            drive_row(r);
            tick();
            c = count_out[r.cwf*CW +: CW];
            chk($sformatf("tbl%0d_count_wf%0d", i, r.cwf), WF*CW'(c), WF*CW'(r.ecnt));
            chk($sformatf("tbl%0d_valid_full", i),
                WF*CW'({valid_entry_out[r.cwf], full_out[r.cwf]}),
                WF*CW'({r.ecnt != 0, r.ecnt == DEPTH}));
            chk($sformatf("tbl%0d_flags", i),
                WF*CW'({overflow_err, underflow_err}), WF*CW'({r.eovf != 0, r.eunf != 0}));
        end

        // rst dominates a same-cycle decode and clears nonzero counts and flags
        drive_row(row(1,0,3, 0,0,0, 0,0,0, 0,0, 0,0,0,0));
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        chk_all_zero("mid_reset");
        tick();
        chk_all_zero("post_reset_idle");

        for (int w = 0; w < WF; w++) mc[w] = 0;
        movf = 0; munf = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int dwf, iw[NI], bwf, fwf, ftag_i;
            int dv, dh, be, bt, fe, iv[NI];
            logic [WF*CW-1:0] ecnt;
            logic [WF-1:0] ev, ef;
            dv = ($urandom_range(0,3) != 0) ? 1 : 0;
            dh = ($urandom_range(0,7) == 0) ? 1 : 0;
            dwf = ($urandom_range(0,9) == 0) ? $urandom_range(40,63) : $urandom_range(0,5);
            for (int p = 0; p < NI; p++) begin
                iv[p] = $urandom_range(0,1);
                iw[p] = ($urandom_range(0,9) == 0) ? $urandom_range(40,63) : $urandom_range(0,5);
            end
            be = ($urandom_range(0,7) == 0) ? 1 : 0;
            bt = $urandom_range(0,1);
            bwf = $urandom_range(0,5);
            fe = ($urandom_range(0,15) == 0) ? 1 : 0;
            fwf = $urandom_range(0,5);
            ftag_i = fwf + 64 * $urandom_range(0,1);
            rst = ($urandom_range(0,499) == 0);
            drive_row(row(dv,dh,dwf, iv[0] + 2*iv[1], iw[0], iw[1], be,bt,bwf, fe,ftag_i, 0,0,0,0));

            if (rst) begin
                for (int w = 0; w < WF; w++) mc[w] = 0;
                movf = 0; munf = 0;
            end else begin
                for (int w = 0; w < WF; w++) begin
                    int s;
                    s = mc[w] + ((dv == 1 && dh == 0 && dwf == w) ? 1 : 0);
                    for (int p = 0; p < NI; p++)
                        if (iv[p] == 1 && iw[p] == w) s = s - 1;
                    if ((be == 1 && bt == 1 && bwf == w) || (fe == 1 && fwf == w)) mc[w] = 0;
                    else if (s < 0) begin mc[w] = 0; munf = 1; end
                    else if (s > DEPTH) begin mc[w] = DEPTH; movf = 1; end
                    else mc[w] = s;
                end
            end
            tick();
            rst = 0;
            for (int w = 0; w < WF; w++) begin
                ecnt[w*CW +: CW] = CW'(mc[w]);
                ev[w] = (mc[w] != 0);
                ef[w] = (mc[w] == DEPTH);
            end
            chk($sformatf("rand%0d_count", cyc), count_out, ecnt);
            chk($sformatf("rand%0d_valid_full", cyc), WF*CW'({valid_entry_out, full_out}), WF*CW'({ev, ef}));
            chk($sformatf("rand%0d_flags", cyc), WF*CW'({overflow_err, underflow_err}),
                WF*CW'({movf != 0, munf != 0}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wf_valid_count.md
# wf_valid_count

Per-wavefront instruction-buffer occupancy tracker for the issue stage. It generalises the single-bit valid-entry register: each wavefront slot holds a saturating counter of pending decoded instructions, up to DEPTH. Decode increments the counter, any of NUM_ISSUE issue ports decrements it, and a taken branch or page fault flushes it to zero. Outputs feed the issue arbiters: valid, full and raw count per wavefront, plus sticky protocol-error flags.

## Interface
- WF_PER_CU, 40, number of wavefront slots
- WFID_W, 6, wavefront ID width; IDs >= WF_PER_CU are ignored
- DEPTH, 2, maximum pending instructions per wavefront (1..15)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > DEPTH
- NUM_ISSUE, 2, number of issue ports (e.g. ALU, LSU)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- decode_valid  in  1  decoded instruction enters buffer
- decode_hold  in  1  instruction is halt/barrier/waitcnt/idempotent-barrier; suppresses increment
- decode_wfid  in  WFID_W  wavefront of decoded instruction
- issue_valid  in  NUM_ISSUE  per-port issue strobe
- issue_wfid  in  NUM_ISSUE*WFID_W  port p uses bits [p*WFID_W +: WFID_W]
- branch_en  in  1  SALU branch resolved
- branch_taken  in  1  resolved branch taken
- branch_wfid  in  WFID_W  branching wavefront
- fault_en  in  1  memory page fault
- fault_tag  in  7  fault tag; bits [WFID_W-1:0] are the wavefront
- valid_entry_out  out  WF_PER_CU  bit w = (count[w] != 0)
- full_out  out  WF_PER_CU  bit w = (count[w] == DEPTH)
- count_out  out  WF_PER_CU*CNT_W  count of wf w at [w*CNT_W +: CNT_W]
- overflow_err  out  1  sticky; increment attempted beyond DEPTH
- underflow_err  out  1  sticky; decrement below zero

## Operation
- Per wf w, each cycle:
  - inc = decode_valid & ~decode_hold & (decode_wfid == w)
  - dec = number of ports p with issue_valid[p] & (issue_wfid[p] == w), range 0..NUM_ISSUE
  - flush = (branch_en & branch_taken & branch_wfid == w) | (fault_en & fault_tag[WFID_W-1:0] == w)
- Priority: flush > arithmetic. Flushed wf goes to 0 regardless of inc/dec; no error flagged for that wf that cycle.
- Otherwise compute sum = count + inc - dec with CNT_W+2 bit signed intermediate:
  - sum < 0: count <= 0, set underflow_err
  - sum > DEPTH: count <= DEPTH, set overflow_err
  - else count <= sum
- Simultaneous inc and dec on the same wf net out; e.g. count=DEPTH, inc=1, dec=1 stays DEPTH with no error.
- Out-of-range IDs (>= WF_PER_CU) match no slot; silently ignored.
- Errors are sticky until rst; they never alter other wavefronts.
- branch_en without branch_taken has no effect.

## Timing
- Reset: all counters 0, valid_entry_out=0, full_out=0, count_out=0, overflow_err=0, underflow_err=0.
- rst dominates all inputs in the same cycle; in-flight state discarded.
- Latency: input at edge N visible on all outputs after edge N (one register stage); outputs are pure functions of registered counts and flags, with no input-to-output combinational path.
- Back-to-back decode every cycle is permitted; full_out is the producer's throttle, and decode into a full wf with no same-cycle issue is an overflow.
- Error flags assert the cycle after the offending update.

## Test plan
- Reset then idle 5 cycles -> all outputs 0.
- DEPTH=2: decode wf 3 on two consecutive cycles -> count[3]=1 then 2; valid_entry_out[3]=1, full_out[3]=1 after second edge; issue port 1 wf 3 -> count 1, full_out[3]=0.
- count[7]=2: decode wf 7 plus issue port 0 wf 7 same cycle -> count stays 2, no error; decode alone next cycle -> count 2, overflow_err=1 and stays 1.
- count[5]=1: both issue ports target wf 5 -> count 0, underflow_err=1; other counts unchanged.
- count[9]=2: decode wf 9 with branch_en=1, branch_taken=1, branch_wfid=9 -> count 0, no error; repeat with fault_en, fault_tag=7'h49 -> wf 9 flushed.
- decode_wfid=45 (>= 40) or decode_hold=1 -> no counter changes; rst asserted mid-sequence with counts nonzero -> all zero next cycle.
